// File: rtl/load_extend_if.sv
// load_extend_if
// Request/response bundle for load_extend_pipe.
//   Request side : in_valid, in_ready, in_data, in_size, in_offset, in_signed
//   Response side: out_valid, out_ready, out_data, out_misaligned
// Modports:
//   master - the agent that issues requests and consumes results
//   slave  - the formatter itself
// DATA_W must match the DATA_W of the attached load_extend_pipe.
interface load_extend_if #(
  parameter int DATA_W = 64
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_size;
  logic [OFF_W-1:0]  in_offset;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_misaligned;

  modport master (
    output in_valid, in_data, in_size, in_offset, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_misaligned
  );

  modport slave (
    input  in_valid, in_data, in_size, in_offset, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_misaligned
  );
endinterface

// File: rtl/load_extend_pipe.sv
// load_extend_pipe
// Pipelined load-data formatter: picks a byte/half/word/dword field out of a
// raw memory word at a byte offset, zero- or sign-extends it to DATA_W and
// flags misaligned requests. A main register (M) feeds the outputs and a skid
// register (S) absorbs one extra request so in_ready is purely registered.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - load_extend_if.slave (request in, result out, valid/ready each)
// Parameters:
//   DATA_W - raw word / result width, 16, 32 or 64
module load_extend_pipe #(
  parameter int DATA_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  load_extend_if.slave  bus
);
  localparam int         OFF_W    = $clog2(DATA_W / 8);
  localparam logic [7:0] DATA_W_B = 8'(DATA_W);

  // ---------------------------------------------------------------------
  // Field extraction and extension (combinational, ahead of register M/S)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext [4];

  // Bring the field LSB down to bit 0; the extenders then only look at
  // the low FW bits.
  assign shifted = bus.in_data >> {bus.in_offset, 3'b000};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_size
      localparam int FW = 8 << gi;
      if (FW < DATA_W) begin : g_narrow
        assign ext[gi] = {{(DATA_W - FW){bus.in_signed & shifted[FW-1]}},
                          shifted[FW-1:0]};
      end else begin : g_full
        // Full-width (or wider, which is always flagged misaligned):
        // nothing to extend.
        assign ext[gi] = shifted;
      end
    end
  endgenerate

  logic [3:0]        fw_bytes;
  logic [3:0]        off_ext;
  logic [7:0]        end_bit;
  logic              req_mis_next;
  logic [DATA_W-1:0] req_data_next;

  assign fw_bytes = 4'd1 << bus.in_size;
  assign off_ext  = 4'(bus.in_offset);
  // One past the field MSB. A field wider than the word always overruns
  // the word here too, so this also covers the too-wide case.
  assign end_bit  = {1'b0, off_ext, 3'b000} + {1'b0, fw_bytes, 3'b000};

  assign req_mis_next  = (|(off_ext & (fw_bytes - 4'd1))) || (end_bit > DATA_W_B);
  assign req_data_next = req_mis_next ? '0 : ext[bus.in_size];

  // ---------------------------------------------------------------------
  // Two-entry output buffer
  // ---------------------------------------------------------------------
  logic              m_valid_reg;
  logic [DATA_W-1:0] m_data_reg;
  logic              m_mis_reg;
  logic              s_valid_reg;
  logic [DATA_W-1:0] s_data_reg;
  logic              s_mis_reg;

  logic in_fire;
  logic out_fire;

  // in_ready comes straight from the skid flag so there is no
  // combinational path from out_ready back to the request side.
  assign in_fire  = bus.in_valid && !s_valid_reg;
  assign out_fire = m_valid_reg && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_mis_reg   <= 1'b0;
      s_valid_reg <= 1'b0;
      s_data_reg  <= '0;
      s_mis_reg   <= 1'b0;
    end else if (!m_valid_reg || out_fire) begin
      // M is free this edge. S, if occupied, is older than any new input
      // (and in_ready is low then, so no input can fire alongside it).
      if (s_valid_reg) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= s_data_reg;
        m_mis_reg   <= s_mis_reg;
        s_valid_reg <= 1'b0;
      end else if (in_fire) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= req_data_next;
        m_mis_reg   <= req_mis_next;
      end else begin
        m_valid_reg <= 1'b0;
        m_data_reg  <= '0;
        m_mis_reg   <= 1'b0;
      end
    end else if (in_fire) begin
      // M is stalled: park the new request in S.
      s_valid_reg <= 1'b1;
      s_data_reg  <= req_data_next;
      s_mis_reg   <= req_mis_next;
    end
  end

  assign bus.in_ready       = !s_valid_reg;
  assign bus.out_valid      = m_valid_reg;
  assign bus.out_data       = m_data_reg;
  assign bus.out_misaligned = m_mis_reg;
endmodule

// File: tb/tb_load_extend_pipe.sv
// tb_load_extend_pipe
// Self-checking bench for load_extend_pipe: a 64-bit and a 32-bit instance,
// directed cases plus randomized streams checked against a behavioural model
// (field extraction by bit loop, in-flight requests held in a queue).
module tb_load_extend_pipe;
  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  load_extend_if #(.DATA_W(64)) bus64 ();
  load_extend_if #(.DATA_W(32)) bus32 ();

  load_extend_pipe #(.DATA_W(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64));
  load_extend_pipe #(.DATA_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {misaligned, data}. Data is computed bit by bit from
  // the field definition; bits at or above dw stay 0.
  function automatic logic [64:0] model(input logic [63:0] d, input logic [1:0] sz,
                                        input int off, input logic sg, input int dw);
    int fw;
    logic [63:0] r;
    fw = 8 << sz;
    r  = '0;
    if (fw > dw || (off % (fw / 8)) != 0 || off * 8 + fw > dw) return {1'b1, 64'd0};
    for (int i = 0; i < dw; i++)
      r[i] = (i < fw) ? d[off * 8 + i] : (sg & d[off * 8 + fw - 1]);
    return {1'b0, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on the 64-bit instance with out_ready high; returns in the
  // cycle right after the accepting edge.
  task automatic send64(input logic [63:0] d, input logic [1:0] sz,
                        input logic [2:0] off, input logic sg);
    bus64.in_data   = d;
    bus64.in_size   = sz;
    bus64.in_offset = off;
    bus64.in_signed = sg;
    bus64.in_valid  = 1'b1;
    bus64.out_ready = 1'b1;
    step();
    bus64.in_valid  = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [1:0] sz,
                        input logic [1:0] off, input logic sg);
    bus32.in_data   = d;
    bus32.in_size   = sz;
    bus32.in_offset = off;
    bus32.in_signed = sg;
    bus32.in_valid  = 1'b1;
    bus32.out_ready = 1'b1;
    step();
    bus32.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks += 8;
    if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset64_out_valid got %b want 0", bus64.out_valid); end
    if (bus64.out_data !== 64'd0) begin n_fail++; $display("FAIL reset64_out_data got %h want 0", bus64.out_data); end
    if (bus64.out_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset64_mis got %b want 0", bus64.out_misaligned); end
    if (bus64.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset64_in_ready got %b want 1", bus64.in_ready); end
    if (bus32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset32_out_valid got %b want 0", bus32.out_valid); end
    if (bus32.out_data !== 32'd0) begin n_fail++; $display("FAIL reset32_out_data got %h want 0", bus32.out_data); end
    if (bus32.out_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset32_mis got %b want 0", bus32.out_misaligned); end
    if (bus32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset32_in_ready got %b want 1", bus32.in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_byte_extend();
    logic [63:0] want [2];
    want[0] = 64'hFFFF_FFFF_FFFF_FF80;
    want[1] = 64'h0000_0000_0000_0080;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL byte_idle_before got %b want 0", bus64.out_valid); end
      send64(64'h80, 2'd0, 3'd0, (k == 0));
      n_checks += 3;
      if (bus64.out_valid !== 1'b1) begin n_fail++; $display("FAIL byte_latency out_valid got %b want 1", bus64.out_valid); end
      if (bus64.out_data !== want[k]) begin n_fail++; $display("FAIL byte_data signed=%0d got %h want %h", (k == 0), bus64.out_data, want[k]); end
      if (bus64.out_misaligned !== 1'b0) begin n_fail++; $display("FAIL byte_mis got %b want 0", bus64.out_misaligned); end
      step();
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL byte_single_beat out_valid got %b want 0", bus64.out_valid); end
      $display("byte extend signed=%0d data=%h", (k == 0), want[k]);
    end
  endtask

  task automatic test_alignment();
    logic [63:0] d   [6];
    logic [1:0]  sz  [6];
    logic [2:0]  off [6];
    logic        sg  [6];
    logic        emis[6];
    logic [63:0] edat[6];
    d[0] = 64'hBEEF_0000_0000_0000; sz[0] = 1; off[0] = 6; sg[0] = 0; emis[0] = 0; edat[0] = 64'h0000_0000_0000_BEEF;
    d[1] = 64'hBEEF_0000_0000_0000; sz[1] = 1; off[1] = 6; sg[1] = 1; emis[1] = 0; edat[1] = 64'hFFFF_FFFF_FFFF_BEEF;
    d[2] = 64'h1234_5678_9ABC_DEF0; sz[2] = 1; off[2] = 3; sg[2] = 1; emis[2] = 1; edat[2] = 64'h0;
    d[3] = 64'h8765_4321_0000_0000; sz[3] = 2; off[3] = 4; sg[3] = 1; emis[3] = 0; edat[3] = 64'hFFFF_FFFF_8765_4321;
    d[4] = 64'hF123_4567_89AB_CDEF; sz[4] = 3; off[4] = 0; sg[4] = 0; emis[4] = 0; edat[4] = 64'hF123_4567_89AB_CDEF;
    d[5] = 64'hF123_4567_89AB_CDEF; sz[5] = 2; off[5] = 6; sg[5] = 0; emis[5] = 1; edat[5] = 64'h0;
    for (int k = 0; k < 6; k++) begin
      send64(d[k], sz[k], off[k], sg[k]);
      n_checks += 3;
      if (bus64.out_valid !== 1'b1) begin n_fail++; $display("FAIL align_valid case %0d got %b want 1", k, bus64.out_valid); end
      if (bus64.out_misaligned !== emis[k]) begin n_fail++; $display("FAIL align_mis case %0d got %b want %b", k, bus64.out_misaligned, emis[k]); end
      if (bus64.out_data !== edat[k]) begin n_fail++; $display("FAIL align_data case %0d got %h want %h", k, bus64.out_data, edat[k]); end
      $display("align case %0d size=%0d off=%0d mis=%b data=%h", k, sz[k], off[k], emis[k], edat[k]);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [64:0] q[$];
    logic [63:0] prev;
    logic        stalled;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stalled = 0; prev = '0;
    while (got < 5 && cyc < 60) begin
      n_checks += 2;
      if (bus64.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want %b", cyc, bus64.in_ready, (q.size() < 2)); end
      if (bus64.out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL bp_out_valid cycle %0d got %b want %b", cyc, bus64.out_valid, (q.size() > 0)); end
      if (q.size() > 0) begin
        n_checks++;
        if (bus64.out_data !== q[0][63:0]) begin n_fail++; $display("FAIL bp_order cycle %0d got %h want %h", cyc, bus64.out_data, q[0][63:0]); end
        if (stalled) begin
          n_checks++;
          if (bus64.out_data !== prev) begin n_fail++; $display("FAIL bp_stable cycle %0d got %h want %h", cyc, bus64.out_data, prev); end
        end
      end
      bus64.out_ready = (cyc >= 4);
      bus64.in_valid  = (sent < 5);
      bus64.in_data   = 64'h1111_1111_1111_1111 * (sent + 1);
      bus64.in_size   = 2'd3;
      bus64.in_offset = 3'd0;
      bus64.in_signed = 1'b0;
      stalled = bus64.out_valid && !bus64.out_ready;
      prev    = bus64.out_data;
      if (bus64.out_valid && bus64.out_ready) begin
        $display("bp out cycle %0d data=%h", cyc, bus64.out_data);
        void'(q.pop_front());
        got++;
      end
      if (bus64.in_valid && bus64.in_ready) begin
        q.push_back({1'b0, bus64.in_data});
        sent++;
      end
      step();
      cyc++;
    end
    bus64.in_valid = 1'b0;
    n_checks++;
    if (got != 5 || sent != 5) begin n_fail++; $display("FAIL bp_count got %0d results want 5", got); end
    step();
  endtask

  task automatic test_random();
    logic [64:0] q[$];
    logic [64:0] exp_v;
    int cyc;
    cyc = 0;
    while (cyc < 400 && !(cyc >= 300 && q.size() == 0)) begin
      n_checks += 2;
      if (bus64.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", cyc, bus64.in_ready, (q.size() < 2)); end
      if (bus64.out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid cycle %0d got %b want %b", cyc, bus64.out_valid, (q.size() > 0)); end
      if (q.size() > 0) begin
        n_checks++;
        if ({bus64.out_misaligned, bus64.out_data} !== q[0]) begin
          n_fail++;
          $display("FAIL rnd_result cycle %0d got mis=%b data=%h want mis=%b data=%h",
                   cyc, bus64.out_misaligned, bus64.out_data, q[0][64], q[0][63:0]);
        end
      end
      if (!(bus64.in_valid && !bus64.in_ready)) begin
        bus64.in_data   = {$urandom, $urandom};
        bus64.in_size   = 2'($urandom_range(0, 3));
        bus64.in_offset = 3'($urandom_range(0, 7));
        bus64.in_signed = 1'($urandom_range(0, 1));
      end
      bus64.in_valid  = (cyc < 300) && ($urandom_range(0, 9) < 7);
      bus64.out_ready = (cyc >= 300) || ($urandom_range(0, 9) < 6);
      if (bus64.out_valid && bus64.out_ready) void'(q.pop_front());
      if (bus64.in_valid && bus64.in_ready) begin
        exp_v = model(bus64.in_data, bus64.in_size, int'(bus64.in_offset), bus64.in_signed, 64);
        q.push_back(exp_v);
        $display("rnd in cycle %0d size=%0d off=%0d sg=%b exp mis=%b data=%h",
                 cyc, bus64.in_size, bus64.in_offset, bus64.in_signed, exp_v[64], exp_v[63:0]);
      end
      step();
      cyc++;
    end
    bus64.in_valid = 1'b0;
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain timeout pending %0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    bus64.out_ready = 1'b0;
    bus64.in_size   = 2'd3;
    bus64.in_offset = 3'd0;
    bus64.in_signed = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus64.in_data  = 64'hDEAD_0000_0000_0000 + 64'(k);
      bus64.in_valid = 1'b1;
      step();
    end
    bus64.in_valid = 1'b0;
    n_checks += 2;
    if (bus64.in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_full in_ready got %b want 0", bus64.in_ready); end
    if (bus64.out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_full out_valid got %b want 1", bus64.out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus64.out_ready = 1'b1;
    n_checks += 3;
    if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid got %b want 0", bus64.out_valid); end
    if (bus64.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready got %b want 1", bus64.in_ready); end
    if (bus64.out_data !== 64'd0) begin n_fail++; $display("FAIL rm_out_data got %h want 0", bus64.out_data); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale cycle %0d out_valid got %b want 0 data=%h", k, bus64.out_valid, bus64.out_data); end
    end
    $display("reset mid-operation done");
  endtask

  task automatic test_w32();
    logic [64:0] exp_v;
    logic [31:0] d;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic        sg;
    send32(32'h1234_5678, 2'd3, 2'd0, 1'b0);
    n_checks += 2;
    if (bus32.out_misaligned !== 1'b1) begin n_fail++; $display("FAIL w32_dword_mis got %b want 1", bus32.out_misaligned); end
    if (bus32.out_data !== 32'd0) begin n_fail++; $display("FAIL w32_dword_data got %h want 0", bus32.out_data); end
    send32(32'h8000_0000, 2'd1, 2'd2, 1'b1);
    n_checks += 2;
    if (bus32.out_misaligned !== 1'b0) begin n_fail++; $display("FAIL w32_half_mis got %b want 0", bus32.out_misaligned); end
    if (bus32.out_data !== 32'hFFFF_8000) begin n_fail++; $display("FAIL w32_half_data got %h want ffff8000", bus32.out_data); end
    for (int k = 0; k < 40; k++) begin
      d   = $urandom;
      sz  = 2'($urandom_range(0, 3));
      off = 2'($urandom_range(0, 3));
      sg  = 1'($urandom_range(0, 1));
      exp_v = model({32'd0, d}, sz, int'(off), sg, 32);
      send32(d, sz, off, sg);
      n_checks += 2;
      if (bus32.out_valid !== 1'b1) begin n_fail++; $display("FAIL w32_rnd_valid %0d got %b want 1", k, bus32.out_valid); end
      if ({bus32.out_misaligned, bus32.out_data} !== {exp_v[64], exp_v[31:0]}) begin
        n_fail++;
        $display("FAIL w32_rnd %0d got mis=%b data=%h want mis=%b data=%h",
                 k, bus32.out_misaligned, bus32.out_data, exp_v[64], exp_v[31:0]);
      end
      $display("w32 rnd %0d size=%0d off=%0d sg=%b mis=%b data=%h", k, sz, off, sg, exp_v[64], exp_v[31:0]);
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_size = '0;
    bus64.in_offset = '0; bus64.in_signed = 1'b0; bus64.out_ready = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_size = '0;
    bus32.in_offset = '0; bus32.in_signed = 1'b0; bus32.out_ready = 1'b0;
    test_reset();
    test_byte_extend();
    test_alignment();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_w32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_extend_pipe.md
# load_extend_pipe

Parametrised, pipelined load-data formatter for the memory-to-register-file path. Selects a byte, halfword, word or doubleword field from a raw memory word at a byte offset, then zero- or sign-extends it to full datapath width. A valid/ready handshake with a two-entry output buffer lets it sit between data memory and writeback in the pipelined core. It replaces fixed-width combinational extenders on the load path and adds alignment checking.

## Interface
- DATA_W, 64, raw word and result width in bits; legal values 16, 32, 64
- OFF_W, $clog2(DATA_W/8), byte-offset width; derived, not overridden
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request this cycle
- in_data  input  DATA_W  raw memory word, byte 0 = bits [7:0]
- in_size  input  2  0=byte, 1=half, 2=word, 3=dword
- in_offset  input  OFF_W  byte offset of the field LSB
- in_signed  input  1  1=sign-extend, 0=zero-extend
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  DATA_W  extended result
- out_misaligned  output  1  request was illegal; out_data forced to 0

## Operation
- Field width FW = 8 << in_size bits. Field = in_data[in_offset*8 +: FW].
- Illegal (misaligned) when FW > DATA_W, or in_offset not a multiple of FW/8, or in_offset*8 + FW > DATA_W. Illegal requests still flow through the pipeline in order with out_misaligned=1 and out_data=0.
- Legal requests: out_data[FW-1:0] = field. Upper bits = field MSB if in_signed, else 0. When FW == DATA_W, in_signed has no effect.
- Storage: main register M (valid, data, misaligned) and skid register S. out_* always drive M.
- Handshake: input fires when in_valid && in_ready. Output fires when out_valid && out_ready.
- in_ready = !S.valid, taken from a register with no combinational path from out_ready.
- Per-edge rules:
  - M empty or output fires:
    - If S is valid, M <= S and S clears.
    - If S is empty, M <= new input when input fires, otherwise M clears.
    - If S is valid and input also fires: impossible, because in_ready=0 whenever S is valid.
  - M full and output does not fire: a firing input goes into S.
- Ordering is strict FIFO. No request is dropped or duplicated.

## Timing
- Reset values: out_valid=0, out_data=0, out_misaligned=0, in_ready=1, M and S invalid.
- Reset asserted mid-operation discards M and S contents on that edge. No output fires in the cycle after reset.
- Latency: an input accepted at edge N is visible on out_* after edge N (out_valid high in cycle N+1) when M was empty or drained at N.
- Throughput: one request per cycle sustained while out_ready=1.
- Backpressure with out_ready low and in_valid high continuously:
  - Two requests are accepted (into M and S).
  - in_ready goes low the cycle after S fills.
  - in_ready returns high the cycle after S drains into M.
- out_data and out_misaligned stay stable while out_valid=1 and out_ready=0.

## Test plan
- Byte sign/zero extend, DATA_W=64, in_data=0x0000_0000_0000_0080, size 0, offset 0:
  - signed -> out_data=0xFFFF_FFFF_FFFF_FF80
  - unsigned -> 0x0000_0000_0000_0080
  - misaligned=0, out_valid exactly 1 cycle after accept
- Half at top, in_data=0xBEEF_0000_0000_0000, size 1, offset 6:
  - unsigned -> 0x0000_0000_0000_BEEF
  - signed -> 0xFFFF_FFFF_FFFF_BEEF
- Alignment errors:
  - size 1, offset 3 -> out_misaligned=1, out_data=0
  - size 2, offset 4 -> legal
  - size 3, offset 0 -> passes in_data through unchanged
- Backpressure: stream 5 back-to-back requests tagged by data, hold out_ready=0 for 4 cycles, then release.
  - in_ready drops after 2 accepts.
  - All 5 results emerge in order, none lost or repeated.
  - Output stays stable while stalled.
- Reset mid-operation: fill M and S, assert reset 1 cycle.
  - out_valid=0 and in_ready=1 after the edge.
  - Old data never appears on out_*.
- DATA_W=32 instance:
  - size 3 -> misaligned=1
  - in_data=0x8000_0000, size 1, offset 2, signed -> 0xFFFF_8000
